mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared instruction/data memory port.
// Round-robin between the CPU (0) and the loader/debug port (1), with an
// optional lock that holds the grant for up to MAX_HOLD cycles under contention.
module mem_port_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned HOLD_W    = 5;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                other_req;

  // State, round-robin pointer and hold counter; reset clears state at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Next-state, hold counter and memory-port mux
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = '0;
    other_req    = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    rdata0       = '0;
    rdata1       = '0;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        other_req = req1;
        gnt0      = 1'b1;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_read  = req0 & ~we0;
        mem_write = req0 & we0;
        if (req0 && !we0) begin
          rdata0 = mem_rdata;
        end
        if (!req0) begin
          state_d = req1 ? OWN1 : IDLE;
        end else if (req1 && (!lock0 || hold_cnt_q == HOLD_LAST)) begin
          state_d = OWN1;
        end
      end
      OWN1: begin
        other_req = req0;
        gnt1      = 1'b1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_read  = req1 & ~we1;
        mem_write = req1 & we1;
        if (req1 && !we1) begin
          rdata1 = mem_rdata;
        end
        if (!req1) begin
          state_d = req0 ? OWN0 : IDLE;
        end else if (req0 && (!lock1 || hold_cnt_q == HOLD_LAST)) begin
          state_d = OWN0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Count only while staying put with the other side waiting
    if (state_d == state_q && state_q != IDLE && other_req) begin
      hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
    end

    if (state_d != state_q) begin
      if (state_d == OWN0) begin
        last_owner_d = 1'b0;
      end else if (state_d == OWN1) begin
        last_owner_d = 1'b1;
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign owner = last_owner_q & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned MAX_HOLD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy, owner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Shared memory: boot image loaded on the first edge, then word writes
  logic [31:0] mem [256];
  logic        boot_done = 1'b0;

  function automatic logic [31:0] boot_word(input int i);
    return (i == 0) ? 32'h3c048000 : (32'hA5000000 | 32'(i));
  endfunction

  always @(posedge clk) begin
    if (!boot_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= boot_word(i);
      boot_done <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
  endtask

  // Reference model: owner index (-1 = nobody), round-robin pointer, hold count
  int m_own, m_last, m_hold;

  task automatic model_reset();
    m_own = -1; m_last = 1; m_hold = 0;
  endtask

  task automatic model_step();
    int nxt;
    logic rx, ry, lx;
    if (m_own < 0) begin
      if (req0 && req1) nxt = 1 - m_last;
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
      else              nxt = -1;
      m_hold = 0;
    end else begin
      rx = (m_own == 0) ? req0 : req1;
      ry = (m_own == 0) ? req1 : req0;
      lx = (m_own == 0) ? lock0 : lock1;
      if (!rx)                                         nxt = ry ? 1 - m_own : -1;
      else if (ry && !lx)                              nxt = 1 - m_own;
      else if (ry && lx && m_hold == int'(MAX_HOLD) - 1) nxt = 1 - m_own;
      else                                             nxt = m_own;
      if (nxt == m_own) m_hold = ry ? ((m_hold < 31) ? m_hold + 1 : 31) : 0;
      else              m_hold = 0;
    end
    if (nxt >= 0 && nxt != m_own) m_last = nxt;
    m_own = nxt;
  endtask

  task automatic model_check();
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata, e_r0, e_r1;
    e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_r0 = 0; e_r1 = 0;
    if (m_own == 0) begin
      e_addr = addr0; e_wdata = wdata0; e_rd = req0 & ~we0; e_wr = req0 & we0;
      if (e_rd) e_r0 = mem[addr0[9:2]];
    end else if (m_own == 1) begin
      e_addr = addr1; e_wdata = wdata1; e_rd = req1 & ~we1; e_wr = req1 & we1;
      if (e_rd) e_r1 = mem[addr1[9:2]];
    end
    chk("rnd_gnt0",  32'(gnt0), 32'(m_own == 0));
    chk("rnd_gnt1",  32'(gnt1), 32'(m_own == 1));
    chk("rnd_addr",  mem_addr, e_addr);
    chk("rnd_wdata", mem_wdata, e_wdata);
    chk("rnd_read",  32'(mem_read), 32'(e_rd));
    chk("rnd_write", 32'(mem_write), 32'(e_wr));
    chk("rnd_rdata0", rdata0, e_r0);
    chk("rnd_rdata1", rdata1, e_r1);
    chk("rnd_busy",  32'(busy), 32'(m_own >= 0));
    chk("rnd_owner", 32'(owner), 32'(m_last));
  endtask

  typedef struct {
    logic r0, r1, w0, w1, l0, l1;
    logic g0, g1, rd, wr, bz;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n1;
    logic switched;

    tbl[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    tbl[1] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1};
    tbl[3] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1};
    tbl[4] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1};
    tbl[5] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
    tbl[6] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b1};
    tbl[7] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1};
    tbl[8] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};

    // Reset with active requests: every output must be zero
    reset = 1; idle_inputs();
    req0 = 1; req1 = 1; addr0 = 32'h44; addr1 = 32'h48;
    wdata0 = 32'h1111_2222; wdata1 = 32'h3333_4444;
    next_neg(); next_neg();
    #1;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_read", 32'(mem_read), 0);
    chk("rst_write", 32'(mem_write), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);

    // Boot read from address 0, one-cycle grant latency
    @(negedge clk);
    reset = 0; idle_inputs(); req0 = 1; addr0 = 32'h0;
    #1;
    chk("lat_gnt0_idle", 32'(gnt0), 0);
    chk("lat_owner_idle", 32'(owner), 1);
    next_neg(); #1;
    chk("boot_gnt0", 32'(gnt0), 1);
    chk("boot_read", 32'(mem_read), 1);
    chk("boot_rdata0", rdata0, 32'h3c048000);
    chk("boot_rdata1", rdata1, 0);
    req0 = 0;
    next_neg();

    // Directed table: alternation, drop-without-bubble, write, return to idle
    addr0 = 32'h0; addr1 = 32'h4;
    for (int i = 0; i < 9; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; we0 = tbl[i].w0; we1 = tbl[i].w1;
      lock0 = tbl[i].l0; lock1 = tbl[i].l1;
      #1;
      chk($sformatf("tbl%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_read", i), 32'(mem_read), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_write", i), 32'(mem_write), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      next_neg();
    end

    // Locked writer 1 against waiting requester 0: 16-cycle hold then switch
    idle_inputs();
    req0 = 1; addr0 = 32'h0;
    req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'h80; wdata1 = 32'hDEADBEEF;
    n1 = 0; switched = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (gnt0 && gnt1) chk("lock_both_gnt", 32'(gnt0 & gnt1), 0);
      if (gnt1) n1++;
      else if (n1 > 0 && gnt0) begin
        switched = 1;
        break;
      end
      next_neg();
    end
    chk("lock_hold_cycles", 32'(n1), 16);
    chk("lock_switch_gnt0", 32'(switched), 1);
    idle_inputs();
    next_neg();
    req0 = 1; addr0 = 32'h80;
    next_neg(); #1;
    chk("word32_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 0;
    next_neg();

    // Idle with no requests
    addr0 = 32'h123; addr1 = 32'h456;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_read", 32'(mem_read), 0);
      chk("idle_write", 32'(mem_write), 0);
      chk("idle_addr", mem_addr, 0);
      next_neg();
    end

    // Reset mid-write in OWN1: write dropped at once and never committed
    req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'h40; wdata1 = 32'h12345678;
    next_neg(); #1;
    chk("midw_write_before", 32'(mem_write), 1);
    reset = 1;
    #1;
    chk("midw_write_dropped", 32'(mem_write), 0);
    chk("midw_gnt1_dropped", 32'(gnt1), 0);
    next_neg();
    chk("midw_no_commit", mem[16], boot_word(16));
    reset = 0; idle_inputs(); req0 = 1; req1 = 1; addr0 = 32'h0; addr1 = 32'h4;
    next_neg(); #1;
    chk("post_rst_gnt0", 32'(gnt0), 1);
    chk("post_rst_gnt1", 32'(gnt1), 0);

    // Randomized traffic against the reference model
    @(negedge clk);
    reset = 1; idle_inputs();
    next_neg();
    reset = 0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      we0  = ($urandom_range(0, 2) == 0);
      we1  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) lock0 = ~lock0;
      if ($urandom_range(0, 7) == 0) lock1 = ~lock1;
      addr0  = {22'($urandom), 8'($urandom_range(0, 15)), 2'b00};
      addr1  = {22'($urandom), 8'($urandom_range(0, 15)), 2'b00};
      wdata0 = $urandom;
      wdata1 = $urandom;
      #1;
      model_check();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
